// File: rtl/vol_level_ctrl.sv
// Saturating volume-level controller: up/down buttons -> thermometer Data bus and binary Level.
// Optional hold-to-repeat is compiled in when VOL_AUTOREPEAT_EN is defined.
module vol_level_ctrl #(
  parameter int LEVELS       = 8,
  parameter int INIT_LEVEL   = 0,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Vol_up,
  input  logic                         Vol_down,
  input  logic                         Mute,
  output logic [LEVELS-1:0]            Data,
  output logic [$clog2(LEVELS+1)-1:0]  Level,
  output logic                         At_max,
  output logic                         At_min,
  output logic                         Step_pulse,
  output logic [1:0]                   Dbg_state
);

  localparam int LW = $clog2(LEVELS + 1);
  localparam logic [LW-1:0] L_MAX  = LW'(LEVELS);
  localparam logic [LW-1:0] L_INIT = LW'(INIT_LEVEL);

  if (LEVELS < 2 || LEVELS > 32) begin : g_bad_levels
    $error("vol_level_ctrl: LEVELS must be in 2..32");
  end
  if (INIT_LEVEL < 0 || INIT_LEVEL > LEVELS) begin : g_bad_init
    $error("vol_level_ctrl: INIT_LEVEL must be in 0..LEVELS");
  end
  if (REPEAT_DELAY < 2 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
    $error("vol_level_ctrl: need REPEAT_DELAY >= 2 and 1 <= REPEAT_RATE <= REPEAT_DELAY");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    UP_HOLD   = 2'd1,
    DOWN_HOLD = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [LW-1:0]     r_level;
  logic [LW-1:0]     w_level_next;
  logic [LEVELS-1:0] r_data;
  logic              r_at_max;
  logic              r_at_min;
  logic              r_step;
  logic              w_inc;
  logic              w_dec;
  logic              w_rpt_fire;

  function automatic logic [LEVELS-1:0] therm(input logic [LW-1:0] lvl);
    logic [LEVELS-1:0] t;
    for (int i = 0; i < LEVELS; i++) begin
      t[i] = (i < int'(lvl));
    end
    return t;
  endfunction

`ifdef VOL_AUTOREPEAT_EN
  localparam int CW = $clog2(REPEAT_DELAY + 1);
  logic [CW-1:0] r_cnt;

  // Counter value j-1 at the j-th edge after the initial step, so the first
  // repeat lands REPEAT_DELAY cycles later; reloading to DELAY-RATE spaces the rest.
  assign w_rpt_fire = (r_cnt == CW'(REPEAT_DELAY - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if ((r_state == UP_HOLD   && w_state_next == UP_HOLD) ||
                 (r_state == DOWN_HOLD && w_state_next == DOWN_HOLD)) begin
      r_cnt <= w_rpt_fire ? CW'(REPEAT_DELAY - REPEAT_RATE) : r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_inc        = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      IDLE: begin
        if (Vol_up && !Vol_down) begin
          w_inc        = 1'b1;
          w_state_next = UP_HOLD;
        end else if (Vol_down && !Vol_up) begin
          w_dec        = 1'b1;
          w_state_next = DOWN_HOLD;
        end else if (Vol_up && Vol_down) begin
          w_state_next = RELEASE;
        end
      end
      UP_HOLD: begin
        if (!Vol_up)       w_state_next = IDLE;
        else if (Vol_down) w_state_next = RELEASE;
        else               w_inc        = w_rpt_fire;
      end
      DOWN_HOLD: begin
        if (!Vol_down)   w_state_next = IDLE;
        else if (Vol_up) w_state_next = RELEASE;
        else             w_dec        = w_rpt_fire;
      end
      default: begin
        if (!Vol_up && !Vol_down) w_state_next = IDLE;
      end
    endcase
  end

  // Saturate at both ends; a blocked step leaves the level (and strobe) untouched.
  always_comb begin
    w_level_next = r_level;
    if (w_inc && r_level != L_MAX)       w_level_next = r_level + 1'b1;
    else if (w_dec && r_level != '0)     w_level_next = r_level - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= RELEASE;
      r_level  <= L_INIT;
      r_data   <= therm(L_INIT);
      r_at_max <= (L_INIT == L_MAX);
      r_at_min <= (L_INIT == '0);
      r_step   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_level  <= w_level_next;
      r_data   <= Mute ? '0 : therm(w_level_next);
      r_at_max <= (w_level_next == L_MAX);
      r_at_min <= (w_level_next == '0);
      r_step   <= (w_level_next != r_level);
    end
  end

  assign Data       = r_data;
  assign Level      = r_level;
  assign At_max     = r_at_max;
  assign At_min     = r_at_min;
  assign Step_pulse = r_step;
  assign Dbg_state  = r_state;

endmodule

// File: tb/tb_vol_level_ctrl.sv
// Directed bench for vol_level_ctrl (LEVELS=8, INIT_LEVEL=0, REPEAT_DELAY=16, REPEAT_RATE=4).
module tb_vol_level_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic       Clk = 1'b0;
  logic       Reset, Vol_up, Vol_down, Mute;
  logic [7:0] Data;
  logic [3:0] Level;
  logic       At_max, At_min, Step_pulse;
  logic [1:0] Dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  vol_level_ctrl #(
    .LEVELS(8), .INIT_LEVEL(0), .REPEAT_DELAY(16), .REPEAT_RATE(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Vol_up(Vol_up), .Vol_down(Vol_down), .Mute(Mute),
    .Data(Data), .Level(Level), .At_max(At_max), .At_min(At_min),
    .Step_pulse(Step_pulse), .Dbg_state(Dbg_state)
  );

  always #5 Clk = ~Clk;

  // Advance one edge; outputs are then read and inputs changed 1 ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic pulse_up(input int n);
    for (int i = 0; i < n; i++) begin
      Vol_up = 1'b1;
      tick();
      Vol_up = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Vol_up = 1'b0; Vol_down = 1'b0; Mute = 1'b0;
    tick(); tick();
    vec_cnt++;
    if (Level !== 4'd0 || Data !== 8'h00) begin
      err_cnt++; $display("FAIL reset_level got L=%0d D=%h exp L=0 D=00", Level, Data);
    end
    vec_cnt++;
    if (At_min !== 1'b1 || At_max !== 1'b0 || Step_pulse !== 1'b0) begin
      err_cnt++; $display("FAIL reset_flags got min=%b max=%b st=%b exp 1 0 0", At_min, At_max, Step_pulse);
    end
    vec_cnt++;
    if (Dbg_state !== S_REL) begin
      err_cnt++; $display("FAIL reset_state got %0d exp %0d", Dbg_state, S_REL);
    end
    Reset = 1'b0;
    tick();
    vec_cnt++;
    if (Dbg_state !== S_IDLE) begin
      err_cnt++; $display("FAIL reset_to_idle got %0d exp %0d", Dbg_state, S_IDLE);
    end
  endtask

  task automatic test_pulses();
    int steps = 0;
    for (int p = 0; p < 3; p++) begin
      Vol_up = 1'b1;
      tick();
      vec_cnt++;
      if (Step_pulse !== 1'b1 || Level !== 4'(p + 1)) begin
        err_cnt++; $display("FAIL pulse_latency got st=%b L=%0d exp st=1 L=%0d", Step_pulse, Level, p + 1);
      end
      steps += int'(Step_pulse);
      Vol_up = 1'b0;
      repeat (3) begin
        tick();
        steps += int'(Step_pulse);
      end
    end
    vec_cnt++;
    if (Level !== 4'd3 || Data !== 8'h07 || At_min !== 1'b0) begin
      err_cnt++; $display("FAIL pulses_result got L=%0d D=%h min=%b exp L=3 D=07 min=0", Level, Data, At_min);
    end
    vec_cnt++;
    if (steps != 3) begin
      err_cnt++; $display("FAIL pulses_count got %0d exp 3", steps);
    end
  endtask

  task automatic test_hold();
    logic [37:0] seen = '0;
    logic [37:0] exp_mask;
    logic [3:0]  exp_level;
    logic [7:0]  exp_data;
`ifdef VOL_AUTOREPEAT_EN
    exp_mask  = 38'h1111110001;
    exp_level = 4'd7;
    exp_data  = 8'h7F;
`else
    exp_mask  = 38'h1;
    exp_level = 4'd1;
    exp_data  = 8'h01;
`endif
    do_reset();
    Vol_up = 1'b1;
    for (int i = 0; i < 38; i++) begin
      tick();
      seen[i] = Step_pulse;
    end
    Vol_up = 1'b0;
    tick();
    vec_cnt++;
    if (seen !== exp_mask) begin
      err_cnt++; $display("FAIL hold_step_offsets got %h exp %h", seen, exp_mask);
    end
    vec_cnt++;
    if (Level !== exp_level || Data !== exp_data) begin
      err_cnt++; $display("FAIL hold_result got L=%0d D=%h exp L=%0d D=%h", Level, Data, exp_level, exp_data);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    pulse_up(10);
    vec_cnt++;
    if (Level !== 4'd8 || Data !== 8'hFF || At_max !== 1'b1) begin
      err_cnt++; $display("FAIL sat_reach_max got L=%0d D=%h max=%b exp L=8 D=ff max=1", Level, Data, At_max);
    end
    Vol_up = 1'b1;
    tick();
    vec_cnt++;
    if (Level !== 4'd8 || Step_pulse !== 1'b0 || At_max !== 1'b1 || Dbg_state !== S_UP) begin
      err_cnt++; $display("FAIL sat_up got L=%0d st=%b max=%b s=%0d exp L=8 st=0 max=1 s=1",
                          Level, Step_pulse, At_max, Dbg_state);
    end
    Vol_up = 1'b0;
    do_reset();
    Vol_down = 1'b1;
    tick();
    vec_cnt++;
    if (Level !== 4'd0 || Step_pulse !== 1'b0 || At_min !== 1'b1 || Dbg_state !== S_DOWN) begin
      err_cnt++; $display("FAIL sat_down got L=%0d st=%b min=%b s=%0d exp L=0 st=0 min=1 s=2",
                          Level, Step_pulse, At_min, Dbg_state);
    end
    Vol_down = 1'b0;
    tick();
  endtask

  task automatic test_both();
    do_reset();
    pulse_up(4);
    Vol_up = 1'b1; Vol_down = 1'b1;
    tick();
    vec_cnt++;
    if (Level !== 4'd4 || Step_pulse !== 1'b0 || Dbg_state !== S_REL) begin
      err_cnt++; $display("FAIL both_press got L=%0d st=%b s=%0d exp L=4 st=0 s=3", Level, Step_pulse, Dbg_state);
    end
    Vol_down = 1'b0;
    tick(); tick();
    vec_cnt++;
    if (Level !== 4'd4 || Step_pulse !== 1'b0 || Dbg_state !== S_REL) begin
      err_cnt++; $display("FAIL both_drop_down got L=%0d st=%b s=%0d exp L=4 st=0 s=3", Level, Step_pulse, Dbg_state);
    end
    Vol_up = 1'b0;
    tick();
    Vol_up = 1'b1;
    tick();
    vec_cnt++;
    if (Level !== 4'd5 || Step_pulse !== 1'b1 || Data !== 8'h1F) begin
      err_cnt++; $display("FAIL both_repress got L=%0d st=%b D=%h exp L=5 st=1 D=1f", Level, Step_pulse, Data);
    end
    Vol_up = 1'b0;
    tick();
  endtask

  task automatic test_mute();
    do_reset();
    pulse_up(3);
    Mute = 1'b1;
    tick();
    vec_cnt++;
    if (Data !== 8'h00 || Level !== 4'd3) begin
      err_cnt++; $display("FAIL mute_on got D=%h L=%0d exp D=00 L=3", Data, Level);
    end
    Vol_up = 1'b1;
    tick();
    vec_cnt++;
    if (Level !== 4'd4 || Step_pulse !== 1'b1 || Data !== 8'h00) begin
      err_cnt++; $display("FAIL mute_step got L=%0d st=%b D=%h exp L=4 st=1 D=00", Level, Step_pulse, Data);
    end
    Vol_up = 1'b0;
    tick();
    Mute = 1'b0;
    tick();
    vec_cnt++;
    if (Data !== 8'h0F || Level !== 4'd4) begin
      err_cnt++; $display("FAIL mute_off got D=%h L=%0d exp D=0f L=4", Data, Level);
    end
  endtask

  task automatic test_reset_hold();
    int steps = 0;
    do_reset();
    pulse_up(4);
    Vol_up = 1'b1;
    tick(); tick(); tick();
    vec_cnt++;
    if (Level !== 4'd5) begin
      err_cnt++; $display("FAIL rh_setup got L=%0d exp L=5", Level);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    vec_cnt++;
    if (Level !== 4'd0 || Dbg_state !== S_REL || Step_pulse !== 1'b0) begin
      err_cnt++; $display("FAIL rh_reset got L=%0d s=%0d st=%b exp L=0 s=3 st=0", Level, Dbg_state, Step_pulse);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      steps += int'(Step_pulse);
    end
    vec_cnt++;
    if (steps != 0 || Level !== 4'd0) begin
      err_cnt++; $display("FAIL rh_held_no_step got steps=%0d L=%0d exp 0 0", steps, Level);
    end
    Vol_up = 1'b0;
    tick();
    Vol_up = 1'b1;
    tick();
    vec_cnt++;
    if (Level !== 4'd1 || Step_pulse !== 1'b1 || Data !== 8'h01) begin
      err_cnt++; $display("FAIL rh_repress got L=%0d st=%b D=%h exp L=1 st=1 D=01", Level, Step_pulse, Data);
    end
    Vol_up = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_pulses();
    test_hold();
    test_saturation();
    test_both();
    test_mute();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
